// File: rtl/rv32_mod_fetch_aligner_if.sv
// Purpose: bundles the fetch-aligner redirect, memory fetch and decoder-side
// handshake signals into one interface.
//   master : the surrounding core/memory/decoder (drives redirect, memory
//            ready/response and decoder ready)
//   slave  : the fetch aligner (drives fetch requests and the instruction
//            presented to the decoder)
interface rv32_mod_fetch_aligner_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_req_valid;
  logic [31:0] fetch_req_addr;
  logic        fetch_req_ready;
  logic        fetch_rsp_valid;
  logic [31:0] fetch_rsp_data;
  logic        fetch_rsp_error;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_is_compressed;
  logic        instr_fetch_error;

  modport master (
    output redirect_valid, redirect_pc, fetch_req_ready,
           fetch_rsp_valid, fetch_rsp_data, fetch_rsp_error, instr_ready,
    input  fetch_req_valid, fetch_req_addr, instr_valid, instruction,
           instr_pc, instr_is_compressed, instr_fetch_error
  );

  modport slave (
    input  redirect_valid, redirect_pc, fetch_req_ready,
           fetch_rsp_valid, fetch_rsp_data, fetch_rsp_error, instr_ready,
    output fetch_req_valid, fetch_req_addr, instr_valid, instruction,
           instr_pc, instr_is_compressed, instr_fetch_error
  );
endinterface

// File: rtl/rv32_mod_fetch_aligner.sv
// Purpose: rv32imc fetch aligner. Fetches aligned 32-bit words, buffers them
// as halfwords in a 4-entry FIFO and presents one naturally aligned
// instruction (16-bit zero-extended or 32-bit, possibly word-straddling) per
// decoder handshake. Handles PC redirects and fetch bus errors.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of rv32_mod_fetch_aligner_if: redirect_valid/pc,
//          fetch_req_valid/addr/ready, fetch_rsp_valid/data/error,
//          instr_valid/ready, instruction, instr_pc, instr_is_compressed,
//          instr_fetch_error
module rv32_mod_fetch_aligner #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  rv32_mod_fetch_aligner_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned HW_W  = 16;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_fetch_addr;
  logic                  r_skip_low;
  logic                  r_rst_d;
  logic [HW_W-1:0]       r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_err;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_out_en;
  logic [PTR_W-1:0]      w_rd_ptr_p1;
  logic [PTR_W-1:0]      w_wr_ptr_p1;
  logic [HW_W-1:0]       w_head;
  logic [HW_W-1:0]       w_next;
  logic                  w_head_err;
  logic                  w_next_err;
  logic                  w_single;
  logic                  w_avail;
  logic                  w_instr_valid;
  logic                  w_pop_fire;
  logic [CNT_W-1:0]      w_pop_n;
  logic [CNT_W-1:0]      w_push_n;
  logic [CNT_W-1:0]      w_free;
  logic                  w_req_valid;
  logic                  w_rsp_take;

  // Outputs held at zero in the reset cycle and the cycle after it.
  assign w_out_en    = ~(rst | r_rst_d);

  // FIFO head decode: an errored or non-11 halfword is a single-entry item.
  assign w_rd_ptr_p1 = r_rd_ptr + PTR_W'(1);
  assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);
  assign w_head      = r_fifo_data[r_rd_ptr];
  assign w_next      = r_fifo_data[w_rd_ptr_p1];
  assign w_head_err  = r_fifo_err[r_rd_ptr];
  assign w_next_err  = r_fifo_err[w_rd_ptr_p1];
  assign w_single    = w_head_err | (w_head[1:0] != 2'b11);
  assign w_avail     = w_single ? (r_count >= CNT_W'(1)) : (r_count >= CNT_W'(2));

  assign w_instr_valid = w_out_en & w_avail;
  assign w_pop_fire    = w_instr_valid & bus.instr_ready;
  assign w_pop_n       = w_pop_fire ? (w_single ? CNT_W'(1) : CNT_W'(2)) : CNT_W'(0);
  assign w_push_n      = w_rsp_take ? (r_skip_low ? CNT_W'(1) : CNT_W'(2)) : CNT_W'(0);
  assign w_free        = CNT_W'(FIFO_DEPTH) - r_count;

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Fetch FSM next state, request and response-accept decode.
  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    w_rsp_take  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A request is never issued alongside a redirect, so an accepted
        // request always has its response consumed by WAIT or DISCARD.
        w_req_valid = w_out_en & ~bus.redirect_valid & (w_free >= CNT_W'(2));
        if (w_req_valid && bus.fetch_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.fetch_rsp_valid) begin
          w_rsp_take  = 1'b1;
          w_state_nxt = bus.fetch_rsp_error ? S_HALT : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (bus.fetch_rsp_valid) w_state_nxt = S_IDLE;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Redirect wins; a still-outstanding response must be dropped first,
    // including one already being discarded.
    if (bus.redirect_valid) begin
      w_rsp_take = 1'b0;
      if (((r_state == S_WAIT) || (r_state == S_DISCARD)) && !bus.fetch_rsp_valid)
        w_state_nxt = S_DISCARD;
      else
        w_state_nxt = S_IDLE;
    end
  end

  // PC, fetch address and halfword FIFO.
  always_ff @(posedge clk) begin
    r_rst_d <= rst;
    if (rst) begin
      r_pc         <= RESET_PC & ~XLEN'(1);
      r_fetch_addr <= RESET_PC & ~XLEN'(3);
      r_skip_low   <= RESET_PC[1];
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_fifo_err   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_fifo_data[i] <= '0;
    end else if (bus.redirect_valid) begin
      r_pc         <= bus.redirect_pc & ~XLEN'(1);
      r_fetch_addr <= bus.redirect_pc & ~XLEN'(3);
      r_skip_low   <= bus.redirect_pc[1];
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else begin
      if (w_pop_fire) begin
        r_pc     <= r_pc + (w_single ? XLEN'(2) : XLEN'(4));
        r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
      end
      if (w_rsp_take) begin
        r_fetch_addr <= r_fetch_addr + XLEN'(4);
        r_skip_low   <= 1'b0;
        if (r_skip_low) begin
          r_fifo_data[r_wr_ptr] <= bus.fetch_rsp_data[31:16];
          r_fifo_err[r_wr_ptr]  <= bus.fetch_rsp_error;
        end else begin
          r_fifo_data[r_wr_ptr]    <= bus.fetch_rsp_data[15:0];
          r_fifo_err[r_wr_ptr]     <= bus.fetch_rsp_error;
          r_fifo_data[w_wr_ptr_p1] <= bus.fetch_rsp_data[31:16];
          r_fifo_err[w_wr_ptr_p1]  <= bus.fetch_rsp_error;
        end
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
      end
      r_count <= r_count + w_push_n - w_pop_n;
    end
  end

  assign bus.fetch_req_valid     = w_req_valid;
  assign bus.fetch_req_addr      = w_out_en ? r_fetch_addr : '0;
  assign bus.instr_valid         = w_instr_valid;
  assign bus.instruction         = !w_out_en ? '0 :
                                   (w_single ? {16'h0000, w_head} : {w_next, w_head});
  assign bus.instr_pc            = w_out_en ? r_pc : '0;
  assign bus.instr_is_compressed = w_out_en & w_single;
  // A 32-bit instruction is tainted if either of its halves was errored.
  assign bus.instr_fetch_error   = w_out_en & (w_head_err | (~w_single & w_next_err));

endmodule

// File: tb/tb_rv32_mod_fetch_aligner.sv
// Bench for rv32_mod_fetch_aligner: an instruction-stream model walks memory
// from the last redirect/reset PC and predicts every decoder handshake.
module tb_rv32_mod_fetch_aligner;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        comp;
    logic        ferr;
  } item_t;

  logic clk;
  logic rst;

  rv32_mod_fetch_aligner_if bus ();

  rv32_mod_fetch_aligner #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  logic [31:0] mem  [1024];
  logic        merr [1024];

  int unsigned p_rdy, p_req_rdy, lat_min, lat_max;
  logic        spur_en, drv_rst, drv_redir;
  logic [31:0] drv_redir_pc;

  logic        pend;
  logic [31:0] pend_addr;
  int unsigned pend_cnt;

  logic [31:0] m_pc, m_errw;
  logic        m_live;

  logic        prev_rst, prev_valid, prev_blk;
  logic [65:0] prev_out;
  item_t       hs_log [$];
  logic [31:0] req_log [$];
  int unsigned req_cycles, valid_cycles, hs_total;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic herr(input logic [31:0] a);
    return merr[a[11:2]];
  endfunction

  // One clock: drive inputs just after the edge, check at the falling edge.
  task automatic cycle();
    logic        hs, acc;
    logic [15:0] lo, hi;
    item_t       a, e;
    int unsigned step;
    rst                 = drv_rst;
    bus.redirect_valid  = drv_redir;
    bus.redirect_pc     = drv_redir_pc;
    bus.fetch_rsp_valid = 1'b0;
    bus.fetch_rsp_data  = $urandom;
    bus.fetch_rsp_error = 1'($urandom_range(1, 0));
    if (pend) begin
      if (pend_cnt == 0) begin
        bus.fetch_rsp_valid = 1'b1;
        bus.fetch_rsp_data  = mem[pend_addr[11:2]];
        bus.fetch_rsp_error = merr[pend_addr[11:2]];
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end else if (spur_en && ($urandom_range(99, 0) < 5)) begin
      bus.fetch_rsp_valid = 1'b1;
    end
    bus.fetch_req_ready = ($urandom_range(99, 0) < p_req_rdy);
    bus.instr_ready     = ($urandom_range(99, 0) < p_rdy);
    @(negedge clk);
    a = '{pc: bus.instr_pc, ins: bus.instruction,
          comp: bus.instr_is_compressed, ferr: bus.instr_fetch_error};
    if (rst || prev_rst) begin
      chk("zero_ctl", 72'({bus.fetch_req_valid, bus.instr_valid, bus.instr_is_compressed,
                           bus.instr_fetch_error, bus.fetch_req_addr}), 72'(0));
      chk("zero_data", 72'({bus.instruction, bus.instr_pc}), 72'(0));
    end
    if (rst) begin
      pend       = 1'b0;
      m_pc       = RST_PC & ~32'h1;
      m_live     = 1'b1;
      prev_valid = 1'b0;
    end else begin
      hs  = bus.instr_valid & bus.instr_ready;
      acc = bus.fetch_req_valid & bus.fetch_req_ready;
      if (prev_valid && !prev_blk)
        chk("stable", 72'({bus.instr_valid, a}), 72'({1'b1, prev_out}));
      if (bus.fetch_req_valid) begin
        req_cycles++;
        chk("req_align", 72'(bus.fetch_req_addr[1:0]), 72'(0));
        chk("one_outstanding", 72'(pend), 72'(0));
        chk("no_req_halted", 72'(m_live), 72'(1));
      end
      if (bus.instr_valid) valid_cycles++;
      if (bus.redirect_valid) begin
        m_pc   = drv_redir_pc & ~32'h1;
        m_live = 1'b1;
      end else if (hs) begin
        hs_total++;
        hs_log.push_back(a);
        chk("instr_after_halt", 72'(m_live), 72'(1));
        if (m_live) begin
          lo = hw(m_pc);
          if (herr(m_pc)) begin
            e = '{pc: m_pc, ins: {16'h0, lo}, comp: 1'b1, ferr: 1'b1};
            m_errw = m_pc;
            step = 2;
          end else if (lo[1:0] != 2'b11) begin
            e = '{pc: m_pc, ins: {16'h0, lo}, comp: 1'b1, ferr: 1'b0};
            step = 2;
          end else begin
            hi = hw(m_pc + 32'd2);
            e = '{pc: m_pc, ins: {hi, lo}, comp: 1'b0, ferr: herr(m_pc + 32'd2)};
            m_errw = m_pc + 32'd2;
            step = 4;
          end
          chk("instr_pc", 72'(a.pc), 72'(e.pc));
          chk("instruction", 72'(a.ins), 72'(e.ins));
          chk("compressed", 72'(a.comp), 72'(e.comp));
          chk("fetch_error", 72'(a.ferr), 72'(e.ferr));
          m_pc = m_pc + 32'(step);
          // Past the end of an errored word the aligner has halted.
          if (e.ferr && (m_pc[31:2] != m_errw[31:2])) m_live = 1'b0;
        end
      end
      if (acc) begin
        pend      = 1'b1;
        pend_addr = bus.fetch_req_addr;
        pend_cnt  = $urandom_range(lat_max, lat_min) - 1;
        req_log.push_back(bus.fetch_req_addr);
      end
      prev_valid = bus.instr_valid;
      prev_blk   = hs | bus.redirect_valid;
      prev_out   = a;
    end
    prev_rst = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic run_hs(input int n, input int unsigned budget, input string name);
    int unsigned k = 0;
    while ((hs_log.size() < n) && (k < budget)) begin
      cycle();
      k++;
    end
    chk({name, "_progress"}, 72'(hs_log.size() >= n), 72'(1));
  endtask

  task automatic chk_item(input string name, input int idx, input item_t exp);
    item_t got = '0;
    if (idx < hs_log.size()) got = hs_log[idx];
    chk(name, 72'(got), 72'(exp));
  endtask

  task automatic chk_req0(input string name, input logic [31:0] exp);
    logic [31:0] got = 32'hFFFF_FFFF;
    if (req_log.size() > 0) got = req_log[0];
    chk(name, 72'(got), 72'(exp));
  endtask

  task automatic redirect(input logic [31:0] pc);
    hs_log.delete();
    req_log.delete();
    drv_redir    = 1'b1;
    drv_redir_pc = pc;
    cycle();
    drv_redir    = 1'b0;
  endtask

  task automatic wait_pend(input string name);
    int unsigned k = 0;
    while (!pend && (k < 30)) begin
      cycle();
      k++;
    end
    chk({name, "_wait_state"}, 72'(pend), 72'(1));
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.fetch_req_ready = 1'b0; bus.fetch_rsp_valid = 1'b0;
    bus.fetch_rsp_data = '0; bus.fetch_rsp_error = 1'b0; bus.instr_ready = 1'b0;
    drv_rst = 1'b1; drv_redir = 1'b0; drv_redir_pc = '0; spur_en = 1'b0;
    p_rdy = 100; p_req_rdy = 100; lat_min = 1; lat_max = 1;
    pend = 1'b0; pend_addr = '0; pend_cnt = 0;
    m_pc = RST_PC; m_errw = '0; m_live = 1'b1;
    prev_rst = 1'b1; prev_valid = 1'b0; prev_blk = 1'b0; prev_out = '0;
    req_cycles = 0; valid_cycles = 0; hs_total = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = $urandom;
      merr[i] = 1'b0;
    end
    @(posedge clk);
    #1;

    // Reset fetch of addi at RESET_PC.
    mem[32'h100 >> 2] = 32'h0050_0093;
    cycle(); cycle();
    drv_rst = 1'b0;
    hs_log.delete(); req_log.delete();
    run_hs(1, 50, "t1");
    chk_req0("t1_first_req", 32'h100);
    chk_item("t1_addi", 0, '{pc: 32'h100, ins: 32'h0050_0093, comp: 1'b0, ferr: 1'b0});

    // Two compressed instructions in one word.
    mem[32'h200 >> 2] = 32'h0001_4501;
    redirect(32'h200);
    run_hs(2, 50, "t2");
    chk_item("t2_cli", 0, '{pc: 32'h200, ins: 32'h0000_4501, comp: 1'b1, ferr: 1'b0});
    chk_item("t2_cnop", 1, '{pc: 32'h202, ins: 32'h0000_0001, comp: 1'b1, ferr: 1'b0});

    // 32-bit instruction straddling a word boundary.
    lat_min = 3; lat_max = 3;
    mem[32'h200 >> 2] = 32'h0093_4501;
    mem[32'h204 >> 2] = 32'hABCD_0050;
    redirect(32'h200);
    run_hs(2, 60, "t3");
    chk_item("t3_cli", 0, '{pc: 32'h200, ins: 32'h0000_4501, comp: 1'b1, ferr: 1'b0});
    chk_item("t3_straddle", 1, '{pc: 32'h202, ins: 32'h0050_0093, comp: 1'b0, ferr: 1'b0});

    // Redirect to an odd halfword while a fetch is outstanding.
    mem[32'h300 >> 2] = 32'h4505_0001;
    redirect(32'h200);
    wait_pend("t4");
    redirect(32'h302);
    run_hs(1, 60, "t4");
    chk_req0("t4_first_req", 32'h300);
    chk_item("t4_high_half", 0, '{pc: 32'h302, ins: 32'h0000_4505, comp: 1'b1, ferr: 1'b0});

    // Fetch error halts fetching until the next redirect.
    lat_min = 1; lat_max = 1;
    mem[32'h400 >> 2]  = 32'h1111_4501;
    merr[32'h400 >> 2] = 1'b1;
    redirect(32'h400);
    run_hs(2, 60, "t5");
    for (int i = 0; i < 20; i++) cycle();
    chk_item("t5_err_lo", 0, '{pc: 32'h400, ins: 32'h0000_4501, comp: 1'b1, ferr: 1'b1});
    chk_item("t5_err_hi", 1, '{pc: 32'h402, ins: 32'h0000_1111, comp: 1'b1, ferr: 1'b1});
    chk("t5_single_req", 72'(req_log.size()), 72'(1));
    mem[32'h80 >> 2] = 32'h0050_0093;
    redirect(32'h80);
    run_hs(1, 50, "t5b");
    chk_req0("t5_resume_req", 32'h80);
    chk_item("t5_resume", 0, '{pc: 32'h80, ins: 32'h0050_0093, comp: 1'b0, ferr: 1'b0});
    merr[32'h400 >> 2] = 1'b0;

    // Decoder stalled with a full buffer, then reset while a fetch is out.
    p_rdy = 0;
    redirect(32'h200);
    for (int i = 0; i < 12; i++) cycle();
    req_cycles = 0; valid_cycles = 0;
    for (int i = 0; i < 10; i++) cycle();
    chk("t6_no_req_full", 72'(req_cycles), 72'(0));
    chk("t6_valid_held", 72'(valid_cycles), 72'(10));
    p_rdy = 100; lat_min = 3; lat_max = 3;
    wait_pend("t6");
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    req_log.delete();
    for (int i = 0; i < 20 && req_log.size() == 0; i++) cycle();
    chk_req0("t6_req_after_rst", RST_PC);

    // Randomized traffic with redirects, resets, errors and stray responses.
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = $urandom;
      merr[i] = ($urandom_range(99, 0) < 3);
    end
    spur_en = 1'b1; lat_min = 1; lat_max = 3; p_req_rdy = 70;
    redirect(32'h0);
    for (int i = 0; i < 4000; i++) begin
      if ((i % 200) == 0) begin
        p_rdy     = $urandom_range(100, 30);
        p_req_rdy = $urandom_range(100, 40);
      end
      drv_rst   = ($urandom_range(999, 0) < 2);
      drv_redir = ($urandom_range(99, 0) < 2);
      if ($urandom_range(9, 0) == 0) drv_redir_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else                           drv_redir_pc = $urandom & 32'h0000_0FFF;
      cycle();
    end
    drv_rst = 1'b0; drv_redir = 1'b0;
    chk("liveness", 72'(hs_total >= 300), 72'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
